// File: rtl/bloonpop_scheduler.sv
// -----------------------------------------------------------------------------
// bloonpop_scheduler
//
// Tracks a small pool of balloon-pop sprite animations. Game logic posts pop
// events, and each event takes the lowest free slot. Every active slot ages by
// one on each frame_start and retires when its lifetime runs out. For each
// pixel, the lowest-index active slot that covers DrawX/DrawY owns that pixel.
// The block then drives sprite-relative coordinates to the pop-sprite renderer.
//
// Ports (all logic in the vga_clk domain):
//   vga_clk      - pixel clock, rising edge
//   reset_n      - asynchronous active-low reset
//   pop_valid    - pop event request
//   pop_x/pop_y  - top-left corner of the new pop sprite
//   pop_ready    - a free slot exists (combinational from the registered mask)
//   frame_start  - one-cycle pulse at the start of each frame
//   DrawX/DrawY  - current pixel coordinates
//   sprite_hit   - registered: the pixel lies inside an active pop
//   RelativeXP/YP- registered: pixel offset inside the owning sprite, 0 on miss
//   active_mask  - one bit per slot, set while the slot is active
//   drop_count   - saturating count of pop_valid cycles refused for lack of a slot
// -----------------------------------------------------------------------------
module bloonpop_scheduler #(
    parameter int NSLOTS      = 4,
    parameter int LIFE_FRAMES = 8,
    parameter int SPRITE_DIM  = 32
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              pop_valid,
    input  logic [9:0]        pop_x,
    input  logic [9:0]        pop_y,
    output logic              pop_ready,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              sprite_hit,
    output logic [9:0]        RelativeXP,
    output logic [9:0]        RelativeYP,
    output logic [NSLOTS-1:0] active_mask,
    output logic [7:0]        drop_count
);

    // Per-slot state
    logic [NSLOTS-1:0] active_q;
    logic [9:0]        x_q    [NSLOTS];
    logic [9:0]        y_q    [NSLOTS];
    logic [7:0]        life_q [NSLOTS];

    logic [7:0]        drop_q;
    logic              hit_q;
    logic [9:0]        relx_q;
    logic [9:0]        rely_q;

    // Combinational helpers
    logic [NSLOTS-1:0] alloc_onehot;
    logic              alloc_found;
    logic              accept;
    logic [NSLOTS-1:0] slot_hit;
    logic              hit_d;
    logic [9:0]        relx_d;
    logic [9:0]        rely_d;

    // pop_ready depends only on the registered mask, never on same-cycle
    // retirement, so a slot freed by this frame_start cannot be reused this edge.
    assign pop_ready = |(~active_q);
    assign accept    = pop_valid && pop_ready;

    // Lowest-index inactive slot, taken from the pre-edge mask.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no
        // path leaves it unassigned, which would infer a latch.
        alloc_onehot = '0;
        alloc_found  = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!active_q[i] && !alloc_found) begin
                alloc_onehot[i] = 1'b1;
                alloc_found     = 1'b1;
            end
        end
    end

    // Per-slot coverage test. The bounds are 11 bits wide, so a sprite near the
    // right/bottom edge cannot wrap around to cover low coordinates.
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            slot_hit[i] = active_q[i]
                && ({1'b0, DrawX} >= {1'b0, x_q[i]})
                && ({1'b0, DrawX} <  ({1'b0, x_q[i]} + 11'(SPRITE_DIM)))
                && ({1'b0, DrawY} >= {1'b0, y_q[i]})
                && ({1'b0, DrawY} <  ({1'b0, y_q[i]} + 11'(SPRITE_DIM)));
        end
    end

    // Priority pick: the lowest-index covering slot owns the pixel.
    always_comb begin
        hit_d  = 1'b0;
        relx_d = '0;
        rely_d = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (slot_hit[i] && !hit_d) begin
                hit_d  = 1'b1;
                relx_d = DrawX - x_q[i];
                rely_d = DrawY - y_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, whatever order they are written in.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the slot arrays are reset as well. They are only a few
            // flops, and a clean state makes mid-frame resets deterministic.
            active_q <= '0;
            for (int i = 0; i < NSLOTS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                life_q[i] <= '0;
            end
            drop_q <= '0;
            hit_q  <= 1'b0;
            relx_q <= '0;
            rely_q <= '0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (accept && alloc_onehot[i]) begin
                    // The target was inactive before the edge, so it is never
                    // aged on its allocation edge.
                    active_q[i] <= 1'b1;
                    x_q[i]      <= pop_x;
                    y_q[i]      <= pop_y;
                    life_q[i]   <= 8'(LIFE_FRAMES);
                end else if (frame_start && active_q[i]) begin
                    life_q[i] <= life_q[i] - 8'd1;
                    if (life_q[i] == 8'd1) begin
                        active_q[i] <= 1'b0;
                    end
                end
            end

            if (pop_valid && !pop_ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            hit_q  <= hit_d;
            relx_q <= relx_d;
            rely_q <= rely_d;
        end
    end

    assign active_mask = active_q;
    assign drop_count  = drop_q;
    assign sprite_hit  = hit_q;
    assign RelativeXP  = relx_q;
    assign RelativeYP  = rely_q;

endmodule

// File: tb/tb_bloonpop_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for bloonpop_scheduler (NSLOTS=4, LIFE_FRAMES=8,
// SPRITE_DIM=32). Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, so each sample shows the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_bloonpop_scheduler;

    logic       vga_clk;
    logic       reset_n;
    logic       pop_valid;
    logic [9:0] pop_x;
    logic [9:0] pop_y;
    logic       pop_ready;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       sprite_hit;
    logic [9:0] RelativeXP;
    logic [9:0] RelativeYP;
    logic [3:0] active_mask;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    bloonpop_scheduler #(
        .NSLOTS      (4),
        .LIFE_FRAMES (8),
        .SPRITE_DIM  (32)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pop_valid   (pop_valid),
        .pop_x       (pop_x),
        .pop_y       (pop_y),
        .pop_ready   (pop_ready),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_hit  (sprite_hit),
        .RelativeXP  (RelativeXP),
        .RelativeYP  (RelativeYP),
        .active_mask (active_mask),
        .drop_count  (drop_count)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle pop request
    task automatic pop(input logic [9:0] x, input logic [9:0] y);
        pop_valid = 1'b1;
        pop_x     = x;
        pop_y     = y;
        tick();
        pop_valid = 1'b0;
    endtask

    // One-cycle frame_start pulse
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        pop_valid   = 1'b0;
        pop_x       = '0;
        pop_y       = '0;
        frame_start = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        tick();
        tick();

        // ---- reset state
        check("rst_mask", active_mask, 0);
        check("rst_hit",  sprite_hit,  0);
        check("rst_relx", RelativeXP,  0);
        check("rst_rely", RelativeYP,  0);
        check("rst_drop", drop_count,  0);
        check("rst_ready", pop_ready,  1);
        reset_n = 1'b1;
        tick();

        // ---- basic allocation and pixel path
        pop(10'd100, 10'd50);
        check("alloc_mask", active_mask, 4'b0001);
        pixel(10'd100, 10'd50);
        check("tl_hit",  sprite_hit, 1);
        check("tl_relx", RelativeXP, 0);
        check("tl_rely", RelativeYP, 0);
        pixel(10'd131, 10'd81);
        check("br_hit",  sprite_hit, 1);
        check("br_relx", RelativeXP, 31);
        check("br_rely", RelativeYP, 31);
        pixel(10'd132, 10'd81);
        check("out_hit",  sprite_hit, 0);
        check("out_relx", RelativeXP, 0);
        check("out_rely", RelativeYP, 0);

        // ---- lifetime: visible through pulse 7, gone on pulse 8
        for (int k = 1; k <= 8; k++) begin
            frame();
            check($sformatf("life_pulse%0d", k), active_mask[0], (k < 8) ? 1 : 0);
        end
        check("life_ready", pop_ready, 1);
        pixel(10'd100, 10'd50);
        check("life_nohit", sprite_hit, 0);

        // ---- fill all four slots
        pop(10'd100, 10'd100);  // slot 0
        pop(10'd400, 10'd400);  // slot 1
        pop(10'd110, 10'd110);  // slot 2
        pop(10'd620, 10'd200);  // slot 3
        check("full_mask",  active_mask, 4'b1111);
        check("full_ready", pop_ready,   0);

        // ---- three refused pops
        pop_valid = 1'b1;
        pop_x     = 10'd0;
        pop_y     = 10'd0;
        tick();
        tick();
        tick();
        pop_valid = 1'b0;
        check("drop3_count", drop_count,  3);
        check("drop3_mask",  active_mask, 4'b1111);
        pixel(10'd5, 10'd5);
        check("drop3_noload", sprite_hit, 0);

        // ---- overlap priority and right-edge handling
        pixel(10'd115, 10'd115);
        check("ovl_hit",  sprite_hit, 1);
        check("ovl_relx", RelativeXP, 15);
        check("ovl_rely", RelativeYP, 15);
        pixel(10'd639, 10'd210);
        check("edge_hit",  sprite_hit, 1);
        check("edge_relx", RelativeXP, 19);
        check("edge_rely", RelativeYP, 10);
        pixel(10'd0, 10'd210);
        check("nowrap_hit", sprite_hit, 0);

        // ---- drop counter saturation
        pop_valid = 1'b1;
        repeat (300) tick();
        pop_valid = 1'b0;
        check("drop_sat", drop_count, 255);

        // ---- asynchronous reset mid-cycle while a pixel is hit
        pixel(10'd115, 10'd115);
        check("pre_rst_hit", sprite_hit, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mask", active_mask, 0);
        check("arst_hit",  sprite_hit,  0);
        check("arst_relx", RelativeXP,  0);
        check("arst_rely", RelativeYP,  0);
        check("arst_drop", drop_count,  0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_mask", active_mask, 0);
        check("post_rst_hit",  sprite_hit,  0);
        check("post_rst_drop", drop_count,  0);

        // ---- simultaneous retire and accept
        pop(10'd100, 10'd50);          // slot 0, life 8
        repeat (7) frame();            // slot 0 at life 1
        check("sim_pre_mask", active_mask, 4'b0001);
        pop(10'd300, 10'd300);         // slots 1..3, life 8
        pop(10'd400, 10'd400);
        pop(10'd500, 10'd400);
        check("sim_full", active_mask, 4'b1111);
        frame_start = 1'b1;
        pop_valid   = 1'b1;
        pop_x       = 10'd50;
        pop_y       = 10'd60;
        tick();
        frame_start = 1'b0;
        pop_valid   = 1'b0;
        check("sim_mask",  active_mask, 4'b1110);
        check("sim_drop",  drop_count,  1);
        check("sim_ready", pop_ready,   1);
        pop(10'd50, 10'd60);
        check("realloc_mask", active_mask, 4'b1111);
        pixel(10'd50, 10'd60);
        check("realloc_hit",  sprite_hit, 1);
        check("realloc_relx", RelativeXP, 0);
        // slots 1..3 hold life 7, the new slot 0 holds life 8
        repeat (7) frame();
        check("realloc_life7", active_mask, 4'b0001);
        frame();
        check("realloc_life8", active_mask, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
